ddfs_rom_sched: RTL and testbench

Multi-channel DDFS scheduler that time-multiplexes one shared sin_rom (256 x 16, one-cycle registered read) across NCH tone channels.
- Holds a frequency control word (FCW) and a phase accumulator per channel.
- On each sample tick, issues one ROM address per channel, captures the returned sine words into per-channel sample registers, then pulses sample_valid.
- Sits between the bus-facing DDFS register file and the sin_rom instance.

---
 rtl/ddfs_sched_pkg.sv | 26 ++
 rtl/ddfs_phase_bank.sv | 68 ++++++
 rtl/ddfs_rom_sched.sv | 263 ++++++++++++++++++++++++++
 tb/tb_ddfs_rom_sched.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddfs_sched_pkg.sv
// ---------------------------------------------------------------------------
// ddfs_sched_pkg
// Shared types and constants for the multi-channel DDFS ROM scheduler.
//   state_t  : scheduler FSM states
//   *_DEF    : default channel count and datapath widths
//   ch_w()   : width of a channel index for n channels
// ---------------------------------------------------------------------------
package ddfs_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NCH_DEF = 4;
    localparam int PW_DEF  = 32;
    localparam int AW_DEF  = 8;
    localparam int DW_DEF  = 16;

    function automatic int ch_w(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/ddfs_phase_bank.sv
// ---------------------------------------------------------------------------
// ddfs_phase_bank
// Per-channel frequency control word and phase accumulator storage.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   wr_en, wr_ch        : config write strobe and target channel
//   wr_fcw              : new FCW for wr_ch
//   wr_ph_clr           : with wr_en, zero the phase of wr_ch
//   acc_en, acc_ch      : advance phase[acc_ch] by fcw[acc_ch] this cycle
//   ph_msb              : top AW bits of phase[acc_ch] (ROM address)
// ---------------------------------------------------------------------------
module ddfs_phase_bank
    import ddfs_sched_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int PW  = PW_DEF,
    parameter int AW  = AW_DEF,
    parameter int CW  = ch_w(NCH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [CW-1:0] wr_ch,
    input  logic [PW-1:0] wr_fcw,
    input  logic          wr_ph_clr,
    input  logic          acc_en,
    input  logic [CW-1:0] acc_ch,
    output logic [AW-1:0] ph_msb
);

    logic [PW-1:0] fcw_r   [NCH];
    logic [PW-1:0] phase_r [NCH];
    logic          wr_ok_s;

    // Out-of-range channel indices (non power-of-two NCH) are ignored.
    assign wr_ok_s = wr_en && (int'(wr_ch) < NCH);

    // Read side: the address tracks the phase before this cycle's accumulate.
    assign ph_msb = phase_r[acc_ch][PW-1 -: AW];

    // FCW/phase register update: a phase clear beats a same-cycle accumulate,
    // and the accumulate always uses the FCW held before the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                fcw_r[i]   <= '0;
                phase_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (wr_ok_s && (wr_ch == CW'(i))) begin
                    fcw_r[i] <= wr_fcw;
                end else begin
                    fcw_r[i] <= fcw_r[i];
                end

                if (wr_ok_s && wr_ph_clr && (wr_ch == CW'(i))) begin
                    phase_r[i] <= '0;
                end else if (acc_en && (acc_ch == CW'(i))) begin
                    phase_r[i] <= phase_r[i] + fcw_r[i];
                end else begin
                    phase_r[i] <= phase_r[i];
                end
            end
        end
    end

endmodule

// File: rtl/ddfs_rom_sched.sv
// ---------------------------------------------------------------------------
// ddfs_rom_sched
// Time-multiplexes one shared sin_rom (one-cycle registered read) across NCH
// DDFS channels. Each tick issues one ROM address per channel, captures the
// returned words into per-channel sample registers and pulses sample_valid.
// Ports:
//   clk, reset        : clock, synchronous active-high reset
//   tick              : sample-rate strobe (dropped and flagged if busy)
//   wr_en/wr_ch/wr_fcw/wr_ph_clr : channel configuration write
//   wr_amp            : per-channel amplitude (DDFS_SCHED_AMP_EN only)
//   clr_ovr           : clear the sticky overrun flag
//   rom_addr/rom_dout : sin_rom address out / data in
//   samples           : packed samples, ch0 in the LSBs
//   sample_valid      : one-cycle pulse when all samples are updated
//   busy, overrun     : scheduler active / tick arrived while active
// Build option: define DDFS_SCHED_AMP_EN to add a registered per-channel
// amplitude multiply (one extra DRAIN cycle).
// ---------------------------------------------------------------------------
module ddfs_rom_sched
    import ddfs_sched_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int PW  = PW_DEF,
    parameter int AW  = AW_DEF,
    parameter int DW  = DW_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  tick,
    input  logic                  wr_en,
    input  logic [ch_w(NCH)-1:0]  wr_ch,
    input  logic [PW-1:0]         wr_fcw,
    input  logic                  wr_ph_clr,
    input  logic                  clr_ovr,
`ifdef DDFS_SCHED_AMP_EN
    input  logic [DW-1:0]         wr_amp,
`endif
    output logic [AW-1:0]         rom_addr,
    input  logic [DW-1:0]         rom_dout,
    output logic [NCH*DW-1:0]     samples,
    output logic                  sample_valid,
    output logic                  busy,
    output logic                  overrun
);

    localparam int            CW     = ch_w(NCH);
    localparam logic [CW-1:0] K_LAST = CW'(NCH - 1);
    localparam logic [CW-1:0] K_ONE  = CW'(1);

    state_t          state_r;
    state_t          state_nx_s;
    logic [CW-1:0]   k_r;
    logic [CW-1:0]   k_nx_s;
    logic            acc_en_s;
    logic [AW-1:0]   ph_msb_s;
    logic [CW-1:0]   k_d_r;
    logic            cap_en_r;
    logic [DW-1:0]   samp_r [NCH];
    logic            sample_valid_r;
    logic            busy_r;
    logic            overrun_r;

    ddfs_phase_bank #(
        .NCH (NCH),
        .PW  (PW),
        .AW  (AW),
        .CW  (CW)
    ) u_phase_bank (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .wr_ch     (wr_ch),
        .wr_fcw    (wr_fcw),
        .wr_ph_clr (wr_ph_clr),
        .acc_en    (acc_en_s),
        .acc_ch    (k_r),
        .ph_msb    (ph_msb_s)
    );

`ifdef DDFS_SCHED_AMP_EN
    logic [DW-1:0]          amp_r [NCH];
    logic signed [2*DW:0]   prod_s;
    logic [DW-1:0]          prod_r;
    logic [CW-1:0]          k_dd_r;
    logic                   cap2_en_r;
    logic                   drain_r;

    // Amplitude registers share the FCW write strobe; reset to full scale.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                amp_r[i] <= {1'b0, {(DW-1){1'b1}}};
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (wr_en && (int'(wr_ch) < NCH) && (wr_ch == CW'(i))) begin
                    amp_r[i] <= wr_amp;
                end else begin
                    amp_r[i] <= amp_r[i];
                end
            end
        end
    end

    // Signed sample times unsigned amplitude (zero-extended to stay positive).
    always_comb begin
        prod_s = '0;
        prod_s = $signed(rom_dout) * $signed({1'b0, amp_r[k_d_r]});
    end

    // Multiply stage: keep bits [2DW-2:DW-1], i.e. product >>> (DW-1) truncated.
    always_ff @(posedge clk) begin
        if (reset) begin
            prod_r    <= '0;
            k_dd_r    <= '0;
            cap2_en_r <= 1'b0;
        end else begin
            prod_r    <= prod_s[2*DW-2:DW-1];
            k_dd_r    <= k_d_r;
            cap2_en_r <= cap_en_r;
        end
    end

    // DRAIN lasts two cycles to let the multiply stage empty.
    always_ff @(posedge clk) begin
        if (reset) begin
            drain_r <= 1'b0;
        end else if (state_r == DRAIN) begin
            drain_r <= ~drain_r;
        end else begin
            drain_r <= 1'b0;
        end
    end

    // Sample capture from the multiply stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                samp_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (cap2_en_r && (k_dd_r == CW'(i))) begin
                    samp_r[i] <= prod_r;
                end else begin
                    samp_r[i] <= samp_r[i];
                end
            end
        end
    end
`else
    // Sample capture: ROM data returns one cycle after its address was issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                samp_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (cap_en_r && (k_d_r == CW'(i))) begin
                    samp_r[i] <= rom_dout;
                end else begin
                    samp_r[i] <= samp_r[i];
                end
            end
        end
    end
`endif

    // Next-state logic: walk k through all channels, then drain the ROM pipe.
    always_comb begin
        state_nx_s = state_r;
        k_nx_s     = k_r;
        acc_en_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (tick) begin
                    state_nx_s = ISSUE;
                    k_nx_s     = '0;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ISSUE: begin
                acc_en_s = 1'b1;
                if (k_r == K_LAST) begin
                    state_nx_s = DRAIN;
                end else begin
                    k_nx_s = k_r + K_ONE;
                end
            end
            DRAIN: begin
`ifdef DDFS_SCHED_AMP_EN
                if (drain_r) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = DRAIN;
                end
`else
                state_nx_s = DONE;
`endif
            end
            DONE: begin
                state_nx_s = IDLE;
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // ROM address is only driven while issuing; it must reach sin_rom this cycle.
    always_comb begin
        rom_addr = '0;
        if (state_r == ISSUE) begin
            rom_addr = ph_msb_s;
        end else begin
            rom_addr = '0;
        end
    end

    // State, channel counter, capture pipe and status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= IDLE;
            k_r            <= '0;
            k_d_r          <= '0;
            cap_en_r       <= 1'b0;
            sample_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            overrun_r      <= 1'b0;
        end else begin
            state_r        <= state_nx_s;
            k_r            <= k_nx_s;
            k_d_r          <= k_r;
            cap_en_r       <= acc_en_s;
            // Flags are registered from the next state so they align with it.
            sample_valid_r <= (state_nx_s == DONE);
            busy_r         <= (state_nx_s != IDLE);
            // A new overrun outranks a same-cycle clear.
            if (tick && (state_r != IDLE)) begin
                overrun_r <= 1'b1;
            end else if (clr_ovr) begin
                overrun_r <= 1'b0;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    // Pack per-channel samples, channel 0 in the LSBs.
    always_comb begin
        samples = '0;
        for (int i = 0; i < NCH; i++) begin
            samples[i*DW +: DW] = samp_r[i];
        end
    end

    assign sample_valid = sample_valid_r;
    assign busy         = busy_r;
    assign overrun      = overrun_r;

endmodule

// File: tb/tb_ddfs_rom_sched.sv
// ---------------------------------------------------------------------------
// tb_ddfs_rom_sched
// Table-driven bench for ddfs_rom_sched with NCH = 4 and a behavioural
// 256 x 16 sine ROM (one-cycle registered read), plus hand-written sequences
// for overrun, mid-ISSUE config write, mid-sequence reset and (when
// DDFS_SCHED_AMP_EN is defined) amplitude scaling.
// ---------------------------------------------------------------------------
module tb_ddfs_rom_sched;

    localparam int NCH = 4;
    localparam int PW  = 32;
    localparam int AW  = 8;
    localparam int DW  = 16;
`ifdef DDFS_SCHED_AMP_EN
    localparam int LAT = 7;
`else
    localparam int LAT = 6;
`endif

    logic              clk;
    logic              reset;
    logic              tick;
    logic              wr_en;
    logic [1:0]        wr_ch;
    logic [PW-1:0]     wr_fcw;
    logic              wr_ph_clr;
    logic              clr_ovr;
    logic [AW-1:0]     rom_addr;
    logic [DW-1:0]     rom_dout;
    logic [NCH*DW-1:0] samples;
    logic              sample_valid;
    logic              busy;
    logic              overrun;
`ifdef DDFS_SCHED_AMP_EN
    logic [DW-1:0]     wr_amp;
    logic [DW-1:0]     amp_val;
`endif

    logic [DW-1:0]     rom_tbl [256];

    int n_vec;
    int n_err;

    ddfs_rom_sched #(
        .NCH (NCH),
        .PW  (PW),
        .AW  (AW),
        .DW  (DW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .tick         (tick),
        .wr_en        (wr_en),
        .wr_ch        (wr_ch),
        .wr_fcw       (wr_fcw),
        .wr_ph_clr    (wr_ph_clr),
        .clr_ovr      (clr_ovr),
`ifdef DDFS_SCHED_AMP_EN
        .wr_amp       (wr_amp),
`endif
        .rom_addr     (rom_addr),
        .rom_dout     (rom_dout),
        .samples      (samples),
        .sample_valid (sample_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural sin_rom: registered read.
    always @(posedge clk) rom_dout <= rom_tbl[rom_addr];

    typedef struct {
        bit          rst;
        bit          wr;
        logic [1:0]  ch;
        logic [31:0] fcw;
        bit          tk;
        logic [63:0] exp_s;
        logic [31:0] exp_a;
    } vec_t;

    vec_t vt [15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
    endtask

    task automatic do_write(input logic [1:0] ch, input logic [31:0] fcw, input logic clr);
        wr_en     = 1'b1;
        wr_ch     = ch;
        wr_fcw    = fcw;
        wr_ph_clr = clr;
`ifdef DDFS_SCHED_AMP_EN
        wr_amp    = amp_val;
`endif
        cyc();
        wr_en     = 1'b0;
        wr_ph_clr = 1'b0;
    endtask

    // Observe cycles start..9 after a tick: latency, pulse count, ISSUE addresses.
    task automatic wait_done(input int start, output int lat, output int nv, output logic [31:0] addrs);
        lat   = -1;
        nv    = 0;
        addrs = '0;
        for (int i = start; i <= 9; i++) begin
            if (i <= NCH) addrs[(i-1)*8 +: 8] = rom_addr;
            if (sample_valid) begin
                nv++;
                if (lat < 0) lat = i;
            end
            cyc();
        end
    endtask

    task automatic run_tick(output int lat, output int nv, output logic [31:0] addrs);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        wait_done(1, lat, nv, addrs);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"},    {63'd0, busy},         64'd0);
        chk({tag, "_valid"},   {63'd0, sample_valid}, 64'd0);
        chk({tag, "_ovr"},     {63'd0, overrun},      64'd0);
        chk({tag, "_addr"},    {56'd0, rom_addr},     64'd0);
        chk({tag, "_samples"}, samples,               64'd0);
    endtask

    initial begin
        int          lat;
        int          nv;
        logic [31:0] addrs;
        real         s;
        int          v;

        for (int a = 0; a < 256; a++) begin
            s = 32767.0 * $sin(2.0 * 3.14159265358979 * a / 256.0);
            if (s >= 0.0) v = $rtoi(s + 0.5);
            else          v = -$rtoi(-s + 0.5);
            rom_tbl[a] = 16'(v);
        end

        n_vec = 0;
        n_err = 0;
        reset = 1'b1; tick = 1'b0; wr_en = 1'b0; wr_ch = 2'd0;
        wr_fcw = 32'd0; wr_ph_clr = 1'b0; clr_ovr = 1'b0;
`ifdef DDFS_SCHED_AMP_EN
        amp_val = 16'h8000;   // unity gain so raw-ROM expectations still hold
        wr_amp  = 16'h0000;
`endif

        //          rst   wr    ch     fcw            tk    exp samples            exp addrs
        vt[0]  = '{1'b1, 1'b0, 2'd0, 32'h00000000, 1'b0, 64'h0,                 32'h0};
        vt[1]  = '{1'b0, 1'b1, 2'd0, 32'h01000000, 1'b0, 64'h0,                 32'h0};
        vt[2]  = '{1'b0, 1'b0, 2'd0, 32'h00000000, 1'b1, 64'h0,                 32'h00000000};
        vt[3]  = '{1'b0, 1'b0, 2'd0, 32'h00000000, 1'b1, 64'h0000000000000324, 32'h00000001};
        vt[4]  = '{1'b0, 1'b0, 2'd0, 32'h00000000, 1'b1, 64'h0000000000000648, 32'h00000002};
        vt[5]  = '{1'b1, 1'b0, 2'd0, 32'h00000000, 1'b0, 64'h0,                 32'h0};
        vt[6]  = '{1'b0, 1'b1, 2'd0, 32'h40000000, 1'b0, 64'h0,                 32'h0};
        vt[7]  = '{1'b0, 1'b1, 2'd1, 32'h40000000, 1'b0, 64'h0,                 32'h0};
        vt[8]  = '{1'b0, 1'b1, 2'd2, 32'h40000000, 1'b0, 64'h0,                 32'h0};
        vt[9]  = '{1'b0, 1'b1, 2'd3, 32'h40000000, 1'b0, 64'h0,                 32'h0};
        vt[10] = '{1'b0, 1'b0, 2'd0, 32'h00000000, 1'b1, 64'h0,                 32'h00000000};
        vt[11] = '{1'b0, 1'b0, 2'd0, 32'h00000000, 1'b1, 64'h7fff7fff7fff7fff, 32'h40404040};
        vt[12] = '{1'b0, 1'b0, 2'd0, 32'h00000000, 1'b1, 64'h0,                 32'h80808080};
        vt[13] = '{1'b0, 1'b0, 2'd0, 32'h00000000, 1'b1, 64'h8001800180018001, 32'hc0c0c0c0};
        vt[14] = '{1'b0, 1'b0, 2'd0, 32'h00000000, 1'b1, 64'h0,                 32'h00000000};

        for (int n = 0; n < 15; n++) begin
            if (vt[n].rst) begin
                do_reset();
                chk_reset_state($sformatf("v%0d_rst", n));
            end
            if (vt[n].wr) do_write(vt[n].ch, vt[n].fcw, 1'b0);
            if (vt[n].tk) begin
                run_tick(lat, nv, addrs);
                chk($sformatf("v%0d_latency", n), 64'(lat),   64'(LAT));
                chk($sformatf("v%0d_npulse", n),  64'(nv),    64'd1);
                chk($sformatf("v%0d_addrs", n),   {32'd0, addrs}, {32'd0, vt[n].exp_a});
            end
            chk($sformatf("v%0d_samples", n), samples, vt[n].exp_s);
        end

        // Overrun: second tick 3 cycles after the first is dropped.
        do_reset();
        tick = 1'b1; cyc(); tick = 1'b0;
        chk("ovr_busy", {63'd0, busy}, 64'd1);
        cyc(); cyc();
        tick = 1'b1; cyc(); tick = 1'b0;
        chk("ovr_set", {63'd0, overrun}, 64'd1);
        wait_done(4, lat, nv, addrs);
        chk("ovr_latency", 64'(lat), 64'(LAT));
        chk("ovr_npulse",  64'(nv),  64'd1);
        chk("ovr_sticky", {63'd0, overrun}, 64'd1);
        // Clear coinciding with a new overrun: the set wins.
        tick = 1'b1; cyc(); tick = 1'b0;
        cyc();
        tick = 1'b1; clr_ovr = 1'b1; cyc(); tick = 1'b0; clr_ovr = 1'b0;
        chk("ovr_set_wins", {63'd0, overrun}, 64'd1);
        wait_done(3, lat, nv, addrs);
        clr_ovr = 1'b1; cyc(); clr_ovr = 1'b0;
        chk("ovr_clear", {63'd0, overrun}, 64'd0);

        // Write with phase clear while channel 2 is being issued.
        do_reset();
        do_write(2'd2, 32'h40000000, 1'b0);
        run_tick(lat, nv, addrs);
        tick = 1'b1; cyc(); tick = 1'b0;
        cyc(); cyc();
        chk("wk2_addr", {56'd0, rom_addr}, 64'h40);
        wr_en = 1'b1; wr_ch = 2'd2; wr_fcw = 32'h02000000; wr_ph_clr = 1'b1;
`ifdef DDFS_SCHED_AMP_EN
        wr_amp = amp_val;
`endif
        cyc();
        wr_en = 1'b0; wr_ph_clr = 1'b0;
        wait_done(4, lat, nv, addrs);
        chk("wk2_latency", 64'(lat), 64'(LAT));
        chk("wk2_sample_old", samples, 64'h00007fff00000000);
        run_tick(lat, nv, addrs);
        chk("wk2_addr_cleared", {32'd0, addrs}, 64'h0);
        chk("wk2_sample_zero", samples, 64'h0);
        run_tick(lat, nv, addrs);
        chk("wk2_addr_new", {32'd0, addrs}, 64'h00020000);
        chk("wk2_sample_new", samples, 64'h0000064800000000);

        // Reset during ISSUE aborts the sequence.
        do_reset();
        do_write(2'd0, 32'h40000000, 1'b0);
        run_tick(lat, nv, addrs);
        run_tick(lat, nv, addrs);
        chk("rst_pre_sample", samples, 64'h0000000000007fff);
        tick = 1'b1; cyc(); tick = 1'b0;
        cyc();
        reset = 1'b1; cyc(); reset = 1'b0;
        chk_reset_state("rst_mid");
        wait_done(1, lat, nv, addrs);
        chk("rst_no_pulse", 64'(nv), 64'd0);
        run_tick(lat, nv, addrs);
        chk("rst_first_latency", 64'(lat), 64'(LAT));
        chk("rst_first_addrs", {32'd0, addrs}, 64'h0);
        chk("rst_first_sample", samples, 64'h0);
        do_write(2'd0, 32'h01000000, 1'b0);
        run_tick(lat, nv, addrs);
        chk("rst_phase0_sample", samples, 64'h0);
        run_tick(lat, nv, addrs);
        chk("rst_phase1_sample", samples, 64'h0000000000000324);

`ifdef DDFS_SCHED_AMP_EN
        // Half-scale amplitude on channel 0 at the sine peak.
        do_reset();
        amp_val = 16'h4000;
        do_write(2'd0, 32'h40000000, 1'b0);
        amp_val = 16'h8000;
        run_tick(lat, nv, addrs);
        chk("amp_latency", 64'(lat), 64'd7);
        run_tick(lat, nv, addrs);
        chk("amp_sample", samples, 64'h0000000000003fff);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
